sga_matrix_scan: RTL and testbench
==================================

Name: sga_matrix_scan

Overview:
- Reader side of the snake-body position RAM. The game datapath writes one 4-bit cell index per body segment, with the head at address 0.
- Once per display frame this block burst-reads segments 0..size-1 and rasterises them into a 16-bit shadow buffer. It then ORs in a blinking apple and swaps the result into a display buffer.
- The display buffer is row-multiplexed onto a 4x4 LED matrix.
- Sits beside the game datapath in the top level; shares the RAM read port under a request/grant handshake.

Parameters:
- ROW_HOLD, 1000, clock cycles each matrix row stays selected; range 2..65535.
- BLINK_FRAMES, 8, frames per apple blink half-period; must be ≥1.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  1 = scanning and fetching; 0 = matrix blanked
- snake_size  in  4  segment count (0 = no snake drawn, max 15)
- apple_pos  in  4  apple cell {y[1:0],x[1:0]}
- apple_valid  in  1  apple present
- rd_req  out  1  request for the RAM read port
- rd_gnt  in  1  read port granted this cycle
- rd_addr  out  4  RAM read address
- rd_data  in  4  cell index {y,x}; valid exactly 1 cycle after an accepted address
- row_sel  out  4  one-hot row drive, active high
- col_on  out  4  column drive for the selected row, active high; bit i = x=i
- frame_done  out  1  1-cycle pulse when the display buffer is updated
- busy  out  1  fetch FSM not in IDLE

Behaviour:
- Reset: all outputs 0; shadow, display buffer, row index, hold counter, frame counter and blink phase all 0; FSM in IDLE.
- Cell mapping: bit index = cell index = y*4+x. Row y drives col_on = disp_buf[4y+3:4y].
- Row scanner:
  - Runs only while enable=1.
  - Hold counter counts 0..ROW_HOLD-1. At wrap, row index advances 0→1→2→3→0.
  - In the first cycle of every row period col_on=0 (anti-ghost blanking); row_sel is already updated in that cycle.
  - With enable=0: row_sel=0, col_on=0, counters held at 0.
- Fetch trigger: the FSM leaves IDLE on the cycle the scanner enters row 0 (hold counter=0, row=0, enable=1). One fetch per frame.
- Fetch FSM states:
  - IDLE → CLEAR.
  - CLEAR: shadow←0; rd_addr←0. If snake_size=0, go to APPLE; otherwise go to REQ.
  - REQ/READ (one state with rd_req=1):
    - Address acceptance: an address is accepted in any cycle where rd_req=1 and rd_gnt=1. The next cycle rd_addr increments.
    - Grant withdrawn: if rd_gnt=0, rd_addr holds. There is no timeout.
    - Data capture: one cycle after each accepted address, shadow[rd_data] ← 1, via a pending-valid flag.
    - End of burst: after address snake_size-1 is accepted, rd_req drops in the next cycle and the FSM moves to DRAIN.
  - DRAIN: the final rd_data is captured → APPLE.
  - APPLE: if apple_valid and blink_phase=1, set shadow[apple_pos] → SWAP.
  - SWAP: disp_buf ← shadow. frame_done=1 for this cycle. Frame counter increments; at BLINK_FRAMES-1 it wraps and blink_phase toggles → IDLE.
- Overlaps: duplicate cell indices (self-collision frame) and apple-on-snake simply OR to 1.
- snake_size sampling: sampled in CLEAR. Changes mid-burst are ignored until the next frame.
- Minimum fetch latency: CLEAR→SWAP takes snake_size+4 cycles with continuous grant. It must complete within one frame (4*ROW_HOLD cycles). If the next row-0 trigger arrives while busy, that trigger is skipped and no frame_done is produced.
- enable drops mid-fetch:
  - FSM → IDLE next cycle; rd_req=0; pending data is discarded.
  - disp_buf and the blink state are unchanged.
- Reset mid-operation: immediate asynchronous clear of all state, including disp_buf.
- The display buffer only changes in SWAP, so a row never shows a half-built frame.

Decomposition:
- Shared package sga_pkg: BOARD_W=4, CELL_W=4, the cell-index→{y,x} field positions, and the fetch-state encoding (IDLE, CLEAR, REQ, DRAIN, APPLE, SWAP).
- One natural sub-module, sga_row_driver: hold counter, row index, blanking cycle, row_sel/col_on generation from disp_buf. It exports a row0_start strobe to the fetch FSM.

Test Plan:
- Reset mid-fetch: assert reset_n=0 while busy → all outputs 0 immediately; after release, first frame_done only after the next row-0 trigger.
- Nominal fetch and display:
  - Stimulus: ROW_HOLD=4, snake_size=3; RAM[0..2]={0x5,0x6,0xA}; rd_gnt tied 1; apple_valid=0.
  - Response: rd_addr 0,1,2 on consecutive cycles; frame_done 7 cycles after the trigger; disp_buf=0x0460.
  - Row 1 period: col_on=0 in its first cycle, then 0x6 for 3 cycles. Row 2: 0x4.
- Grant stall:
  - Stimulus: same setup, with rd_gnt=0 for 3 cycles after address 1 is accepted.
  - Response: rd_addr holds at 2 during the stall; no extra shadow bits; final disp_buf=0x0460; fetch latency +3.
- Apple blink:
  - Stimulus: BLINK_FRAMES=2, snake_size=0, apple_pos=0xF, apple_valid=1.
  - Response: disp_buf=0x0000 for frames 1–2, 0x8000 for frames 3–4, 0x0000 for frames 5–6.
  - Row 3 col_on alternates between 0x8 and 0x0 accordingly.
- Overlap and enable abort:
  - Stimulus: snake_size=2, RAM={0x3,0x3}, apple at 0x3 → disp_buf=0x0008.
  - Then drop enable during the REQ state → rd_req=0 next cycle, row_sel=0, col_on=0, disp_buf still 0x0008, no frame_done.

Source files
------------

// File: rtl/sga_matrix_scan_pkg.sv
// Shared board geometry, cell-index field layout and fetch-state encoding
// for the snake matrix reader.
package sga_pkg;

  localparam int BOARD_W    = 4;                  // cells per row / rows per board
  localparam int CELL_W     = 4;                  // bits in a cell index
  localparam int NCELL      = BOARD_W * BOARD_W;  // bits in a frame bitmap
  localparam int COORD_W    = 2;                  // bits in one coordinate
  localparam int CELL_Y_LSB = 2;                  // cell index = {y[1:0], x[1:0]}

  typedef logic [CELL_W-1:0] cell_t;

  // Fetch FSM encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_APPLE = 3'd4;
  localparam logic [2:0] ST_SWAP  = 3'd5;

  // Column nibble of row y in a frame bitmap (bit index = y*4+x)
  function automatic logic [BOARD_W-1:0] row_of(input logic [NCELL-1:0] bmp,
                                                input logic [COORD_W-1:0] y);
    return bmp[(int'(y) << CELL_Y_LSB) +: BOARD_W];
  endfunction

endpackage

// File: rtl/sga_matrix_scan_if.sv
// Read-port handshake toward the shared snake-body position RAM.
// The scanner is master (drives request/address), the arbiter+RAM is slave.
interface sga_matrix_scan_if;
  logic          rd_req;
  logic          rd_gnt;
  sga_pkg::cell_t rd_addr;
  sga_pkg::cell_t rd_data;

  modport master (output rd_req, output rd_addr, input rd_gnt, input rd_data);
  modport slave  (input rd_req, input rd_addr, output rd_gnt, output rd_data);
endinterface

// File: rtl/sga_matrix_scan_row_driver.sv
// Row multiplexer for the 4x4 LED matrix: hold counter, row index, one blank
// cycle at the start of every row period, and the frame-start strobe.
module sga_row_driver
  import sga_pkg::*;
#(
  parameter int ROW_HOLD = 1000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable_i,
  input  logic [NCELL-1:0]   disp_buf_i,
  output logic [BOARD_W-1:0] row_sel_o,
  output logic [BOARD_W-1:0] col_on_o,
  output logic               row0_start_o
);

  localparam int            HW        = $clog2(ROW_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(ROW_HOLD - 1);

  // enable is registered so outputs come up cleanly one cycle after it,
  // and the scan always starts from a fresh row-0 period
  logic               en_q;
  logic [HW-1:0]      hold_q, hold_d;
  logic [COORD_W-1:0] row_q, row_d;

  // hold counter / row index next state; parked at 0 while disabled
  always_comb begin
    hold_d = hold_q;
    row_d  = row_q;
    if (!en_q) begin
      hold_d = '0;
      row_d  = '0;
    end else if (hold_q == HOLD_LAST) begin
      hold_d = '0;
      row_d  = row_q + 1'b1;
    end else begin
      hold_d = hold_q + 1'b1;
    end
  end

  // scanner state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      en_q   <= 1'b0;
      hold_q <= '0;
      row_q  <= '0;
    end else begin
      en_q   <= enable_i;
      hold_q <= hold_d;
      row_q  <= row_d;
    end
  end

  assign row0_start_o = en_q && (hold_q == '0) && (row_q == '0);
  assign row_sel_o    = en_q ? (BOARD_W'(1) << row_q) : '0;
  // first cycle of each row period is blanked to stop ghosting
  assign col_on_o     = (en_q && (hold_q != '0)) ? row_of(disp_buf_i, row_q) : '0;

endmodule

// File: rtl/sga_matrix_scan.sv
// Snake matrix reader: once per display frame, burst-reads the body cells
// from the shared RAM, rasterises them plus a blinking apple into a shadow
// bitmap, then swaps it into the display buffer driven by the row scanner.
module sga_matrix_scan
  import sga_pkg::*;
#(
  parameter int ROW_HOLD     = 1000,
  parameter int BLINK_FRAMES = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [CELL_W-1:0]    snake_size,
  input  cell_t                apple_pos,
  input  logic                 apple_valid,
  sga_matrix_scan_if.master    rd,
  output logic [BOARD_W-1:0]   row_sel,
  output logic [BOARD_W-1:0]   col_on,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int            FW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  logic [2:0]        state_q, state_d;
  logic [NCELL-1:0]  shadow_q, shadow_d;
  logic [NCELL-1:0]  disp_q, disp_d;
  cell_t             addr_q, addr_d;
  logic [CELL_W-1:0] size_q, size_d;
  logic              cap_vld_q, cap_vld_d;   // rd_data valid this cycle
  logic [FW-1:0]     frm_q, frm_d;
  logic              blink_q, blink_d;
  logic              row0_start;

  // fetch FSM, rasteriser and frame/blink bookkeeping
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    addr_d    = addr_q;
    size_d    = size_q;
    cap_vld_d = 1'b0;
    frm_d     = frm_q;
    blink_d   = blink_q;

    // data for the address accepted last cycle; duplicates simply OR in
    if (cap_vld_q && enable) shadow_d[rd.rd_data] = 1'b1;

    if (!enable) begin
      // abort: display buffer and blink state are left untouched
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (row0_start) state_d = ST_CLEAR;
        ST_CLEAR: begin
          shadow_d = '0;
          addr_d   = '0;
          size_d   = snake_size;
          state_d  = (snake_size == '0) ? ST_APPLE : ST_REQ;
        end
        ST_REQ: begin
          // no grant: hold the address and wait, no timeout
          if (rd.rd_gnt) begin
            cap_vld_d = 1'b1;
            addr_d    = addr_q + 1'b1;
            if (addr_q == size_q - 1'b1) state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: state_d = ST_APPLE;
        ST_APPLE: begin
          if (apple_valid && blink_q) shadow_d[apple_pos] = 1'b1;
          state_d = ST_SWAP;
        end
        ST_SWAP: begin
          disp_d = shadow_q;
          if (frm_q == FRM_LAST) begin
            frm_d   = '0;
            blink_d = ~blink_q;
          end else begin
            frm_d = frm_q + 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // fetch-side state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      shadow_q  <= '0;
      disp_q    <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      cap_vld_q <= 1'b0;
      frm_q     <= '0;
      blink_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      cap_vld_q <= cap_vld_d;
      frm_q     <= frm_d;
      blink_q   <= blink_d;
    end
  end

  assign rd.rd_req  = (state_q == ST_REQ);
  assign rd.rd_addr = addr_q;
  assign frame_done = (state_q == ST_SWAP) && enable;
  assign busy       = (state_q != ST_IDLE);

  sga_row_driver #(.ROW_HOLD(ROW_HOLD)) u_row (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable_i     (enable),
    .disp_buf_i   (disp_q),
    .row_sel_o    (row_sel),
    .col_on_o     (col_on),
    .row0_start_o (row0_start)
  );

endmodule

// File: tb/tb_sga_matrix_scan.sv
// Scoreboard bench for sga_matrix_scan: expected frame images are queued
// when a scenario is configured and compared against the scanned matrix
// each time frame_done fires.
module tb_sga_matrix_scan;

  localparam int RH = 4;
  localparam int BF = 2;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] snake_size = '0;
  logic [3:0] apple_pos = '0;
  logic       apple_valid = 1'b0;
  logic [3:0] row_sel, col_on;
  logic       frame_done, busy;

  sga_matrix_scan_if rd_if();

  sga_matrix_scan #(.ROW_HOLD(RH), .BLINK_FRAMES(BF)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .snake_size(snake_size), .apple_pos(apple_pos), .apple_valid(apple_valid),
    .rd(rd_if), .row_sel(row_sel), .col_on(col_on),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RAM model with optional grant stall after address 1; idle data is 0xF
  logic [3:0] ram [16];
  logic       stall_en = 1'b0;
  int         stall_cnt = 0;

  always_comb rd_if.rd_gnt = (stall_cnt == 0);

  always @(posedge clock) begin
    rd_if.rd_data <= (rd_if.rd_req && rd_if.rd_gnt) ? ram[rd_if.rd_addr] : 4'hF;
    if (!reset_n)            stall_cnt <= 0;
    else if (stall_cnt != 0) stall_cnt <= stall_cnt - 1;
    else if (stall_en && rd_if.rd_req && rd_if.rd_gnt && rd_if.rd_addr == 4'd1)
      stall_cnt <= 3;
  end

  // monitors: cycle count, row-0 start time, address sequence, frame count
  int         cyc = 0, t0 = 0, fd_total = 0, exp_addr = 0;
  logic [3:0] prev_rs = '0;
  logic       prev_busy = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (row_sel == 4'b0001 && prev_rs != 4'b0001) t0 <= cyc;
    prev_rs   <= row_sel;
    prev_busy <= busy;
    if (reset_n) begin
      if (busy && !prev_busy) exp_addr <= 0;
      else if (rd_if.rd_req && rd_if.rd_gnt) begin
        chk("addr", 32'(rd_if.rd_addr), 32'(exp_addr));
        exp_addr <= exp_addr + 1;
      end else if (rd_if.rd_req)
        chk("stall_addr", 32'(rd_if.rd_addr), 32'(exp_addr));
      if (frame_done) fd_total <= fd_total + 1;
    end
  end

  // scoreboard
  logic [15:0] img_q[$];
  int          mdl_n = 0;
  logic        fd_pend = 1'b0;

  function automatic logic [15:0] model_img(input int phase);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < int'(snake_size); i++) m[ram[i]] = 1'b1;
    if (apple_valid && phase != 0) m[apple_pos] = 1'b1;
    return m;
  endfunction

  task automatic push_frames(input int n);
    for (int i = 0; i < n; i++) begin
      img_q.push_back(model_img((mdl_n / BF) % 2));
      mdl_n++;
    end
  endtask

  function automatic int ridx(input logic [3:0] rs);
    case (rs)
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return 0;
    endcase
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   32'(rd_if.rd_req),  0);
    chk({tag, "_addr"},  32'(rd_if.rd_addr), 0);
    chk({tag, "_rsel"},  32'(row_sel),       0);
    chk({tag, "_col"},   32'(col_on),        0);
    chk({tag, "_fdone"}, 32'(frame_done),    0);
    chk({tag, "_busy"},  32'(busy),          0);
  endtask

  task automatic wait_fd(output logic ok);
    int n;
    ok = 1'b1;
    n  = 0;
    if (fd_pend) fd_pend = 1'b0;
    else begin
      do begin
        @(negedge clock);
        n++;
      end while (!frame_done && n < 300);
      if (!frame_done) begin
        chk("fd_timeout", 0, 1);
        ok = 1'b0;
      end
    end
  endtask

  // walk the four rows following the one active at frame_done
  task automatic scan_img(input logic [15:0] exp, input int r0);
    logic stop;
    int   y, n;
    stop = 1'b0;
    for (int k = 1; k <= 4 && !stop; k++) begin
      y = (r0 + k) % 4;
      n = 0;
      while (!stop && row_sel != (4'b0001 << y)) begin
        @(negedge clock);
        n++;
        if (frame_done) begin fd_pend = 1'b1; stop = 1'b1; end
        if (n >= 64) begin chk("row_timeout", 0, 1); stop = 1'b1; end
      end
      if (!stop) begin
        chk($sformatf("blank_row%0d", y), 32'(col_on), 0);
        if (frame_done) begin fd_pend = 1'b1; stop = 1'b1; end
        for (int j = 1; j < RH && !stop; j++) begin
          @(negedge clock);
          chk($sformatf("col_row%0d", y), 32'(col_on), 32'(exp[y*4 +: 4]));
          if (frame_done) begin fd_pend = 1'b1; stop = 1'b1; end
        end
      end
    end
  endtask

  task automatic run_frames(input int n, input int exp_lat, input int exp_acc);
    logic        ok;
    logic [15:0] e;
    for (int i = 0; i < n; i++) begin
      wait_fd(ok);
      if (!ok) break;
      e = (img_q.size() != 0) ? img_q.pop_front() : 16'hDEAD;
      chk("latency", 32'(cyc - t0), 32'(exp_lat));
      chk("n_accept", 32'(exp_addr), 32'(exp_acc));
      scan_img(e, ridx(row_sel));
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    img_q.delete();
    mdl_n   = 0;
    fd_pend = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int n, fd0;
    for (int i = 0; i < 16; i++) ram[i] = 4'h0;
    // nominal: cells 5, 6, A -> 0x0460
    enable = 1'b1; snake_size = 4'd3; apple_valid = 1'b0; apple_pos = 4'h0;
    ram[0] = 4'h5; ram[1] = 4'h6; ram[2] = 4'hA;
    #2 chk_all_zero("rst");
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    push_frames(2);
    run_frames(2, 7, 3);

    // reset while the burst is in flight
    n = 0;
    while (!rd_if.rd_req && n < 100) begin @(negedge clock); n++; end
    chk("req_before_rst", 32'(rd_if.rd_req), 1);
    reset_n = 1'b0;
    #1 chk_all_zero("midrst");
    img_q.delete(); mdl_n = 0; fd_pend = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    push_frames(1);
    run_frames(1, 7, 3);

    // grant withdrawn for 3 cycles after address 1
    stall_en = 1'b1;
    do_reset();
    push_frames(2);
    run_frames(2, 10, 3);
    stall_en = 1'b0;

    // blinking apple alone in the corner cell
    snake_size = 4'd0; apple_pos = 4'hF; apple_valid = 1'b1;
    do_reset();
    push_frames(6);
    run_frames(6, 3, 0);

    // self-collision plus apple on the same cell
    snake_size = 4'd2; ram[0] = 4'h3; ram[1] = 4'h3; apple_pos = 4'h3;
    do_reset();
    push_frames(2);
    run_frames(2, 6, 2);

    // drop enable during the burst
    n = 0;
    while (!rd_if.rd_req && n < 100) begin @(negedge clock); n++; end
    chk("req_before_abort", 32'(rd_if.rd_req), 1);
    fd0    = fd_total;
    enable = 1'b0;
    @(negedge clock);
    chk("abort_req",  32'(rd_if.rd_req), 0);
    chk("abort_rsel", 32'(row_sel), 0);
    chk("abort_col",  32'(col_on), 0);
    chk("abort_busy", 32'(busy), 0);
    repeat (40) @(negedge clock);
    chk("abort_no_fd", 32'(fd_total), 32'(fd0));
    // re-enable: row 0 still shows the last completed frame
    enable = 1'b1;
    n = 0;
    while (row_sel != 4'b0001 && n < 20) begin @(negedge clock); n++; end
    chk("reen_blank", 32'(col_on), 0);
    @(negedge clock);
    chk("reen_row0", 32'(col_on), 32'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
